// File: rtl/inst_fetch_pkg.sv
// Shared processor definitions: fetch FSM states and default sizing constants
// used by the instruction-fetch unit and its testbench.
package inst_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam int          PC_W_DEF    = 10;
  localparam int          IW_DEF      = 9;
  localparam logic [5:0]  HALT_OP_DEF = 6'b111111;
  localparam int          RETIRED_W   = 16;

endpackage

// File: rtl/inst_fetch_if.sv
// Bus between the fetch unit and the rest of the core: ROM word, decoder
// flags, stall, and the fetch unit's pc/status outputs.
interface inst_fetch_if #(
  parameter int PC_W = inst_fetch_pkg::PC_W_DEF,
  parameter int IW   = inst_fetch_pkg::IW_DEF
) ();

  logic            start;
  logic [IW-1:0]   instr;
  logic            stall;
  logic            br_cond;
  logic            alu_zero;
  logic [7:0]      br_offset;
  logic [PC_W-1:0] pc;
  logic [5:0]      addr;
  logic            instr_valid;
  logic            done;
  logic [15:0]     retired;

  modport master (
    output start, instr, stall, br_cond, alu_zero, br_offset,
    input  pc, addr, instr_valid, done, retired
  );

  modport slave (
    input  start, instr, stall, br_cond, alu_zero, br_offset,
    output pc, addr, instr_valid, done, retired
  );

endinterface

// File: rtl/inst_fetch_pc_next.sv
// Next-pc datapath: either pc+1 or pc plus a sign-extended 8-bit offset,
// both wrapping modulo 2^PC_W.
module pc_next #(
  parameter int PC_W = inst_fetch_pkg::PC_W_DEF
) (
  input  logic [PC_W-1:0] i_pc,
  input  logic [7:0]      i_offset,
  input  logic            i_take_branch,
  output logic [PC_W-1:0] o_pc_next
);

  logic [PC_W-1:0] w_offset_ext;
  logic [PC_W-1:0] w_pc_inc;
  logic [PC_W-1:0] w_pc_branch;

  assign w_offset_ext = PC_W'($signed(i_offset));
  assign w_pc_inc     = i_pc + PC_W'(1);
  assign w_pc_branch  = i_pc + w_offset_ext;
  assign o_pc_next    = i_take_branch ? w_pc_branch : w_pc_inc;

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch unit: IDLE/RUN/HALT sequencer owning the program counter
// and a saturating retired-instruction counter.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int         PC_W    = PC_W_DEF,
  parameter int         IW      = IW_DEF,
  parameter logic [5:0] HALT_OP = HALT_OP_DEF
) (
  input  logic         Clk,
  input  logic         Reset,
  inst_fetch_if.slave  bus
);

  state_t                r_state;
  logic [PC_W-1:0]       r_pc;
  logic [RETIRED_W-1:0]  r_retired;

  logic [PC_W-1:0]       w_pc_next;
  logic                  w_take_branch;
  logic                  w_is_halt;
  logic                  w_retire;
  logic [RETIRED_W-1:0]  w_retired_inc;
  logic                  w_unused_instr;

  assign bus.addr        = bus.instr[8:3];
  assign w_unused_instr  = ^bus.instr[2:0];
  assign w_is_halt       = (bus.addr == HALT_OP);
  assign w_take_branch   = bus.br_cond & bus.alu_zero;
  assign w_retire        = (r_state == RUN) & ~bus.stall;
  assign w_retired_inc   = (r_retired == '1) ? r_retired : r_retired + RETIRED_W'(1);

  assign bus.pc          = r_pc;
  assign bus.retired     = r_retired;
  assign bus.instr_valid = w_retire;
  assign bus.done        = (r_state == HALT);

  pc_next #(
    .PC_W (PC_W)
  ) u_pc_next (
    .i_pc          (r_pc),
    .i_offset      (bus.br_offset),
    .i_take_branch (w_take_branch),
    .o_pc_next     (w_pc_next)
  );

  // Halt wins over branch; a halting instruction still counts as retired.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state   <= IDLE;
      r_pc      <= '0;
      r_retired <= '0;
    end else begin
      case (r_state)
        IDLE, HALT: begin
          if (bus.start) begin
            r_state   <= RUN;
            r_pc      <= '0;
            r_retired <= '0;
          end
        end
        RUN: begin
          if (!bus.stall) begin
            r_retired <= w_retired_inc;
            if (w_is_halt) begin
              r_state <= HALT;
            end else begin
              r_pc <= w_pc_next;
            end
          end
        end
        default: begin
          r_state   <= IDLE;
          r_pc      <= '0;
          r_retired <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: stimulus pushes the pc expected to retire,
// a negedge monitor pops and compares whenever instr_valid is high.
module tb_inst_fetch;

  localparam logic [8:0] NOP  = 9'h000;
  localparam logic [8:0] HLT  = 9'h1F8;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;

  int checks   = 0;
  int failures = 0;
  int validCnt = 0;
  int expQ[$];

  inst_fetch_if #(.PC_W(10), .IW(9)) bus ();

  inst_fetch #(.PC_W(10), .IW(9), .HALT_OP(6'b111111)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Drives one cycle of inputs and, if the cycle should retire, queues its pc.
  task automatic applyStimulus(input logic [8:0] ins, input logic stl, input logic bc, input logic az,
                               input logic [7:0] off, input logic st, input bit push, input int expPc);
    bus.instr     = ins;
    bus.stall     = stl;
    bus.br_cond   = bc;
    bus.alu_zero  = az;
    bus.br_offset = off;
    bus.start     = st;
    if (push) expQ.push_back(expPc);
    @(posedge Clk);
    #1;
  endtask

  task automatic startPulse();
    applyStimulus(NOP, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0);
    bus.start = 1'b0;
    checkOutput("start_pc", 32'(bus.pc), 0);
    checkOutput("start_retired", 32'(bus.retired), 0);
    checkOutput("start_done", 32'(bus.done), 0);
  endtask

  always @(negedge Clk) begin
    if (!Reset && bus.instr_valid) begin
      validCnt++;
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_retire actual_pc=%0d required=no_retire", bus.pc);
      end else begin
        checkOutput("retire_pc", 32'(bus.pc), 32'(expQ.pop_front()));
      end
    end
  end

  initial begin
    bus.start = 1'b0; bus.instr = NOP; bus.stall = 1'b0;
    bus.br_cond = 1'b0; bus.alu_zero = 1'b0; bus.br_offset = 8'h00;

    #2;
    checkOutput("reset_pc", 32'(bus.pc), 0);
    checkOutput("reset_retired", 32'(bus.retired), 0);
    checkOutput("reset_done", 32'(bus.done), 0);
    checkOutput("reset_valid", 32'(bus.instr_valid), 0);
    @(posedge Clk); #1;
    Reset = 1'b0;

    // Five NOPs then halt.
    startPulse();
    validCnt = 0;
    for (int i = 0; i < 5; i++) applyStimulus(NOP, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, i);
    applyStimulus(HLT, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 5);
    checkOutput("prog1_done", 32'(bus.done), 1);
    checkOutput("prog1_retired", 32'(bus.retired), 6);
    checkOutput("prog1_pc", 32'(bus.pc), 5);
    for (int i = 0; i < 2; i++) applyStimulus(HLT, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0);
    checkOutput("prog1_pc_hold", 32'(bus.pc), 5);
    checkOutput("prog1_valid_cycles", 32'(validCnt), 6);

    // Taken branch -4 at pc 10, then not-taken at pc 10, then halt with branch flags set.
    startPulse();
    for (int i = 0; i < 10; i++) applyStimulus(NOP, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, i);
    applyStimulus(NOP, 1'b0, 1'b1, 1'b1, 8'hFC, 1'b0, 1'b1, 10);
    checkOutput("br_taken_pc", 32'(bus.pc), 6);
    for (int i = 6; i < 10; i++) applyStimulus(NOP, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, i);
    applyStimulus(NOP, 1'b0, 1'b1, 1'b0, 8'hFC, 1'b0, 1'b1, 10);
    checkOutput("br_not_taken_pc", 32'(bus.pc), 11);
    applyStimulus(NOP, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 11);
    applyStimulus(HLT, 1'b0, 1'b1, 1'b1, 8'hFC, 1'b0, 1'b1, 12);
    checkOutput("halt_over_branch_pc", 32'(bus.pc), 12);
    checkOutput("prog2_done", 32'(bus.done), 1);
    checkOutput("prog2_retired", 32'(bus.retired), 18);

    // Full pc walk with a 3-cycle stall at pc 7, wrap 1023->0, then branch -5 from pc 2.
    startPulse();
    for (int i = 0; i < 1024; i++) begin
      if (i == 7) begin
        for (int s = 0; s < 3; s++) begin
          applyStimulus(HLT, 1'b1, 1'b1, 1'b1, 8'hFC, 1'b0, 1'b0, 0);
          checkOutput("stall_valid", 32'(bus.instr_valid), 0);
          checkOutput("stall_pc", 32'(bus.pc), 7);
          checkOutput("stall_retired", 32'(bus.retired), 7);
        end
      end
      applyStimulus(NOP, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, i);
      if (i == 7) checkOutput("after_stall_pc", 32'(bus.pc), 8);
    end
    checkOutput("wrap_pc", 32'(bus.pc), 0);
    applyStimulus(NOP, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 0);
    applyStimulus(NOP, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1);
    applyStimulus(NOP, 1'b0, 1'b1, 1'b1, 8'hFB, 1'b0, 1'b1, 2);
    checkOutput("br_neg_wrap_pc", 32'(bus.pc), 1021);
    applyStimulus(HLT, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1021);
    checkOutput("prog3_retired", 32'(bus.retired), 1028);
    checkOutput("prog3_done", 32'(bus.done), 1);

    // Start while running is ignored; async reset at pc 20 clears state before the next edge.
    startPulse();
    for (int i = 0; i < 20; i++)
      applyStimulus(NOP, 1'b0, 1'b0, 1'b0, 8'h00, (i == 15), 1'b1, i);
    bus.start = 1'b0;
    checkOutput("pre_reset_pc", 32'(bus.pc), 20);
    checkOutput("pre_reset_retired", 32'(bus.retired), 20);
    bus.stall = 1'b1;
    #1 Reset = 1'b1;
    #1;
    checkOutput("async_reset_pc", 32'(bus.pc), 0);
    checkOutput("async_reset_retired", 32'(bus.retired), 0);
    checkOutput("async_reset_done", 32'(bus.done), 0);
    checkOutput("async_reset_valid", 32'(bus.instr_valid), 0);
    #1 Reset = 1'b0;
    bus.stall = 1'b0;
    startPulse();

    // Long NOP run to drive retired into saturation, then halt.
    for (int i = 0; i < 65540; i++) applyStimulus(NOP, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, i % 1024);
    checkOutput("sat_retired", 32'(bus.retired), 32'h0000FFFF);
    applyStimulus(HLT, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 4);
    checkOutput("sat_halt_retired", 32'(bus.retired), 32'h0000FFFF);
    checkOutput("sat_halt_pc", 32'(bus.pc), 4);
    checkOutput("sat_halt_done", 32'(bus.done), 1);

    applyStimulus(NOP, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0);
    checkOutput("scoreboard_drained", 32'(expQ.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
